// File: rtl/line_walker.sv
// -----------------------------------------------------------------------------
// line_walker
//
// Walks one line segment in x, one pixel per cycle, accumulating y by a signed
// fixed-point slope. Sits between the signed divider, which supplies the
// slope, and the framebuffer write port. Both sides use valid/ready
// handshakes.
//
// Parameters
//   N     slope width, two's complement fixed point
//   FRAC  fractional bits of slope
//   W     pixel coordinate width, unsigned
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   command present
//   in_ready   block can accept a command (high only in IDLE)
//   x0, y0     start point
//   x1         end x, inclusive
//   slope      dy/dx, signed Q(N-FRAC).FRAC
//   pix_valid  pix_x/pix_y valid
//   pix_ready  sink accepts pixel
//   pix_x      pixel x
//   pix_y      pixel y, rounded and clamped to [0, 2^W-1]
//   done       one-cycle pulse after the last pixel is accepted
// -----------------------------------------------------------------------------
module line_walker #(
  parameter int N    = 32,
  parameter int FRAC = 16,
  parameter int W    = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] x1,
  input  logic [N-1:0] slope,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [W-1:0] pix_x,
  output logic [W-1:0] pix_y,
  output logic         done
);

  // The accumulator needs W+FRAC+2 bits for the supported slope range; it is
  // widened to N when the slope is wider so the whole slope is carried.
  localparam int AW_MIN = W + FRAC + 2;
  localparam int AW     = (N > AW_MIN) ? N : AW_MIN;
  localparam int YW     = AW - FRAC;  // width of the signed integer part

  // 0.5 in accumulator units: adding it before truncation rounds half up.
  localparam logic [AW-1:0] HALF = {{(AW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Captured command
  logic [W-1:0]          x0_q, x1_q, y0_q;
  logic [N-1:0]          slope_q;

  // Walk state
  logic                  dir_neg;   // walking towards smaller x
  logic [W:0]            count;     // pixels still to emit, including current
  logic [W-1:0]          cur_x;
  logic signed [AW-1:0]  acc;       // y in fixed point
  logic signed [AW-1:0]  step;      // slope, negated for leftward walks

  logic signed [AW-1:0]  slope_ext;
  logic signed [YW-1:0]  y_int;
  logic                  cmd_fire;
  logic                  pix_fire;
  logic                  last_pix;

  assign slope_ext = AW'($signed(slope_q));
  assign cmd_fire  = in_valid && in_ready;
  assign pix_fire  = pix_valid && pix_ready;
  assign last_pix  = (count == {{W{1'b0}}, 1'b1});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pix_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = STEP;
      end
      STEP: begin
        pix_valid = 1'b1;
        if (pix_ready && last_pix) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: every register here is cleared on reset, so an aborted line leaves
  // pix_x/pix_y at zero rather than at stale coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      slope_q <= '0;
      dir_neg <= 1'b0;
      count   <= '0;
      cur_x   <= '0;
      acc     <= '0;
      step    <= '0;
    end else begin
      if (cmd_fire) begin
        x0_q    <= x0;
        x1_q    <= x1;
        y0_q    <= y0;
        slope_q <= slope;
      end

      if (state == LOAD) begin
        dir_neg <= (x1_q < x0_q);
        count   <= (x1_q >= x0_q) ? ({1'b0, x1_q} - {1'b0, x0_q} + 1'b1)
                                  : ({1'b0, x0_q} - {1'b0, x1_q} + 1'b1);
        step    <= (x1_q >= x0_q) ? slope_ext : -slope_ext;
        acc     <= $signed(AW'({y0_q, {FRAC{1'b0}}}) + HALF);
        cur_x   <= x0_q;
      end

      // The final handshake leaves the walk registers alone; DONE follows.
      if (state == STEP && pix_fire && !last_pix) begin
        cur_x <= dir_neg ? cur_x - 1'b1 : cur_x + 1'b1;
        acc   <= acc + step;
        count <= count - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel outputs: straight from registers, so they hold across stalls.
  // ---------------------------------------------------------------------------
  assign y_int = acc[AW-1:FRAC];
  assign pix_x = cur_x;

  always_comb begin
    pix_y = y_int[W-1:0];
    if (y_int[YW-1]) begin
      pix_y = '0;                      // below the screen
    end else if (|y_int[YW-2:W]) begin
      pix_y = '1;                      // above the screen
    end
  end

endmodule

// File: tb/tb_line_walker.sv
// -----------------------------------------------------------------------------
// tb_line_walker
//
// Self-checking bench for line_walker: a table of directed lines with their
// expected pixels, a stalled replay, a reset-mid-line sequence, and random
// lines checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_line_walker;

  localparam int N    = 32;
  localparam int FRAC = 16;
  localparam int W    = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x0, y0, x1;
  logic [N-1:0] slope;
  logic         pix_valid;
  logic         pix_ready;
  logic [W-1:0] pix_x, pix_y;
  logic         done;

  int checks = 0;
  int errors = 0;

  int exp_x[$];
  int exp_y[$];

  line_walker #(.N(N), .FRAC(FRAC), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .slope     (slope),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0]        x0, y0, x1;
    logic [N-1:0]        slope;
    int                  n;
    logic [3:0][W-1:0]   ex;   // element [0] is the first pixel
    logic [3:0][W-1:0]   ey;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: y = floor(y0 + 0.5 + i*dy), clamped to the screen.
  task automatic build_expect(input int ax0, input int ay0, input int ax1, input int s);
    longint a;
    longint y;
    int     dir;
    int     n;
    exp_x.delete();
    exp_y.delete();
    dir = (ax1 >= ax0) ? 1 : -1;
    n   = ((ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1) + 1;
    a   = longint'(ay0) * 65536 + 32768;
    for (int i = 0; i < n; i++) begin
      y = a >>> FRAC;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      exp_x.push_back(ax0 + dir * i);
      exp_y.push_back(int'(y));
      a = a + longint'(dir) * longint'(s);
    end
  endtask

  // Applies one command and checks every cycle up to in_ready returning.
  // mode 0: pix_ready always 1 (exact timing); 1: fixed 1,0,0,1,0,1 pattern;
  // 2: random pix_ready.
  task automatic run_line(input logic [W-1:0] ax0, input logic [W-1:0] ay0,
                          input logic [W-1:0] ax1, input logic [N-1:0] s,
                          input int mode);
    int idx;
    int cyc;
    int budget;
    int n;
    logic r;
    logic [5:0] pattern;
    pattern = 6'b101001;  // bit 0 first: 1,0,0,1,0,1
    n      = exp_x.size();
    budget = 8 * n + 20;

    @(negedge clk);
    check("idle in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x0 = ax0; y0 = ay0; x1 = ax1; slope = s;

    @(negedge clk);
    in_valid = 1'b0;
    // Scramble the command inputs: they must be ignored from here on.
    x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); slope = $urandom;
    check("load pix_valid", 32'(pix_valid), 32'd0);
    check("load in_ready", 32'(in_ready), 32'd0);

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < budget) begin
      @(negedge clk);
      check("step pix_valid", 32'(pix_valid), 32'd1);
      check("step pix_x", 32'(pix_x), 32'(exp_x[idx]));
      check("step pix_y", 32'(pix_y), 32'(exp_y[idx]));
      check("step done", 32'(done), 32'd0);
      check("step in_ready", 32'(in_ready), 32'd0);
      case (mode)
        0:       r = 1'b1;
        1:       r = pattern[cyc % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      pix_ready = r;
      if (r) idx++;
      cyc++;
    end
    check("pixel count before budget", 32'(idx), 32'(n));

    @(negedge clk);
    pix_ready = 1'($urandom_range(0, 1));
    check("done pulse", 32'(done), 32'd1);
    check("done pix_valid", 32'(pix_valid), 32'd0);
    check("done in_ready", 32'(in_ready), 32'd0);

    @(negedge clk);
    pix_ready = 1'b0;
    check("done single cycle", 32'(done), 32'd0);
    check("ready after done", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; slope = '0;

    vecs[0] = '{x0: 10'd0, y0: 10'd0, x1: 10'd3, slope: 32'h0000_8000, n: 4,
                ex: {10'd3, 10'd2, 10'd1, 10'd0}, ey: {10'd2, 10'd1, 10'd1, 10'd0}};
    vecs[1] = '{x0: 10'd5, y0: 10'd10, x1: 10'd3, slope: 32'h0001_0000, n: 3,
                ex: {10'd0, 10'd3, 10'd4, 10'd5}, ey: {10'd0, 10'd8, 10'd9, 10'd10}};
    vecs[2] = '{x0: 10'd7, y0: 10'd4, x1: 10'd7, slope: 32'h1234_5678, n: 1,
                ex: {10'd0, 10'd0, 10'd0, 10'd7}, ey: {10'd0, 10'd0, 10'd0, 10'd4}};
    vecs[3] = '{x0: 10'd0, y0: 10'd1, x1: 10'd3, slope: 32'hFFFF_0000, n: 4,
                ex: {10'd3, 10'd2, 10'd1, 10'd0}, ey: {10'd0, 10'd0, 10'd0, 10'd1}};
    vecs[4] = '{x0: 10'd0, y0: 10'd1020, x1: 10'd3, slope: 32'h0002_0000, n: 4,
                ex: {10'd3, 10'd2, 10'd1, 10'd0}, ey: {10'd1023, 10'd1023, 10'd1022, 10'd1020}};

    // Reset state
    #3;
    check("reset pix_valid", 32'(pix_valid), 32'd0);
    check("reset pix_x", 32'(pix_x), 32'd0);
    check("reset pix_y", 32'(pix_y), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table, no back-pressure
    for (int v = 0; v < 5; v++) begin
      exp_x.delete();
      exp_y.delete();
      for (int j = 0; j < vecs[v].n; j++) begin
        exp_x.push_back(int'(vecs[v].ex[j]));
        exp_y.push_back(int'(vecs[v].ey[j]));
      end
      run_line(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].slope, 0);
    end

    // First table line again with pix_ready toggling
    exp_x = '{0, 1, 2, 3};
    exp_y = '{0, 1, 1, 2};
    run_line(10'd0, 10'd0, 10'd3, 32'h0000_8000, 1);

    // Reset in the middle of a 10-pixel line
    @(negedge clk);
    in_valid = 1'b1;
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd9; slope = '0;
    @(negedge clk);
    in_valid  = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("pre-reset pix_valid", 32'(pix_valid), 32'd1);
      check("pre-reset pix_x", 32'(pix_x), 32'(i));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort pix_valid", 32'(pix_valid), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort pix_x", 32'(pix_x), 32'd0);
    check("abort pix_y", 32'(pix_y), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("in reset pix_valid", 32'(pix_valid), 32'd0);
      check("in reset done", 32'(done), 32'd0);
    end
    rst_n     = 1'b1;
    pix_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("after reset pix_valid", 32'(pix_valid), 32'd0);
      check("after reset done", 32'(done), 32'd0);
    end
    build_expect(0, 0, 1, 0);
    run_line(10'd0, 10'd0, 10'd1, 32'd0, 0);

    // Random lines against the reference model
    for (int t = 0; t < 40; t++) begin
      int rx0, rx1, ry0, rs, lo, hi;
      rx0 = int'($urandom_range(0, 1023));
      lo  = (rx0 >= 63) ? rx0 - 63 : 0;
      hi  = (rx0 <= 960) ? rx0 + 63 : 1023;
      rx1 = int'($urandom_range(hi, lo));
      ry0 = int'($urandom_range(0, 1023));
      rs  = int'($urandom_range(0, 2 * (1 << 20))) - (1 << 20);
      build_expect(rx0, ry0, rx1, rs);
      run_line(W'(rx0), W'(ry0), W'(rx1), N'(rs), (t % 3 == 0) ? 0 : 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
